// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - hardwired Moore control unit for the Mini-SRC datapath
//
// Steps through fetch (T0-T2) and execute (T3-T7) for the instruction held in IR.
// Every datapath control strobe is decoded combinationally from the state register and IR.
//
// Ports:
//   Clock, Clear          rising-edge clock, asynchronous active-high reset
//   IR[31:0]              opcode IR[31:27]; register fields are decoded by the datapath
//   CON_FF                branch condition, qualifies PCin in the last branch step
//   Stop                  level request to halt once the current instruction completes
//   PCin..Yin             register load enables
//   PCout..Cout           bus drivers
//   Gra..BAout            register-file select and control
//   Read, Write, IncPC, CON_In   memory control, PC increment, CON_FF load
//   OP[4:0]               ALU operation code
//   Run                   1 while sequencing fetch/execute states
module control_sequencer #(
  parameter logic [4:0] OPC_ADD  = 5'b00011,
  parameter logic [4:0] OPC_HALT = 5'b11011
) (
  input  logic        Clock,
  input  logic        Clear,
  input  logic [31:0] IR,
  input  logic        CON_FF,
  input  logic        Stop,
  output logic        PCin, IRin, HIin, LOin, ZHighin, ZLowin, MARin, MDRin, OutPort, Yin,
  output logic        PCout, HIout, LOout, ZHighout, ZLowout, InPort, MDRout, Cout,
  output logic        Gra, Grb, Grc, Rin, Rout, BAout,
  output logic        Read, Write, IncPC, CON_In,
  output logic [4:0]  OP,
  output logic        Run
);

  typedef enum logic [3:0] {
    RST, T0, T1, T2, T3, T4, T5, T6, T7, HALT
  } state_t;

  state_t     state_q, state_d;
  state_t     last_state;
  logic [4:0] opc;

  assign opc = IR[31:27];

  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) state_q <= RST;
    else       state_q <= state_d;
  end

  // Final execute step of the current instruction.
  always_comb begin
    last_state = T3;
    case (opc) inside
      5'b00000, 5'b00010:          last_state = T7;  // ld, st
      [5'b00001:5'b01110]:         last_state = T5;  // ldi, ALU R-type, immediates
      5'b01111, 5'b10000, 5'b10011: last_state = T6; // mul, div, br
      5'b10001, 5'b10010:          last_state = T4;  // neg, not
      default:                     last_state = T3;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RST:  state_d = T0;
      T0:   state_d = T1;
      T1:   state_d = T2;
      T2:   state_d = T3;
      HALT: state_d = HALT;
      default: begin
        if (state_q == T3 && opc == OPC_HALT) state_d = HALT;
        else if (state_q == last_state)       state_d = Stop ? HALT : T0;
        else begin
          case (state_q)
            T3:      state_d = T4;
            T4:      state_d = T5;
            T5:      state_d = T6;
            T6:      state_d = T7;
            default: state_d = T0;
          endcase
        end
      end
    endcase
  end

  always_comb begin
    {PCin, IRin, HIin, LOin, ZHighin, ZLowin, MARin, MDRin, OutPort, Yin} = '0;
    {PCout, HIout, LOout, ZHighout, ZLowout, InPort, MDRout, Cout}        = '0;
    {Gra, Grb, Grc, Rin, Rout, BAout}                                     = '0;
    {Read, Write, IncPC, CON_In}                                          = '0;
    OP  = 5'b00000;
    Run = (state_q != RST) && (state_q != HALT);
    case (state_q)
      T0: begin PCout = 1'b1; MARin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
      T1: IncPC = 1'b1;
      T2: begin MDRout = 1'b1; IRin = 1'b1; end
      T3: begin
        case (opc) inside
          [5'b00011:5'b01011], [5'b01100:5'b01110]: begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
          5'b01111, 5'b10000: begin Gra = 1'b1; Rout = 1'b1; Yin = 1'b1; end
          5'b10001, 5'b10010: begin Grb = 1'b1; Rout = 1'b1; ZLowin = 1'b1; OP = opc; end
          5'b00000, 5'b00001, 5'b00010: begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
          5'b10011: begin Gra = 1'b1; Rout = 1'b1; CON_In = 1'b1; end
          5'b10100: begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
          5'b10110: begin InPort = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          5'b10111: begin Gra = 1'b1; Rout = 1'b1; OutPort = 1'b1; end
          5'b11000: begin Gra = 1'b1; HIout = 1'b1; Rin = 1'b1; end
          5'b11001: begin Gra = 1'b1; LOout = 1'b1; Rin = 1'b1; end
          default: ;
        endcase
      end
      T4: begin
        case (opc) inside
          [5'b00011:5'b01011]: begin Grc = 1'b1; Rout = 1'b1; ZLowin = 1'b1; OP = opc; end
          5'b01111, 5'b10000: begin Grb = 1'b1; Rout = 1'b1; ZHighin = 1'b1; ZLowin = 1'b1; OP = opc; end
          5'b10001, 5'b10010: begin ZLowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          // Immediate forms reuse the matching register ALU code: addi->add, andi->and, ori->or.
          5'b01100: begin Cout = 1'b1; ZLowin = 1'b1; OP = OPC_ADD;  end
          5'b01101: begin Cout = 1'b1; ZLowin = 1'b1; OP = 5'b00101; end
          5'b01110: begin Cout = 1'b1; ZLowin = 1'b1; OP = 5'b00110; end
          5'b00000, 5'b00001, 5'b00010: begin Cout = 1'b1; ZLowin = 1'b1; OP = OPC_ADD; end
          5'b10011: begin PCout = 1'b1; Yin = 1'b1; end
          default: ;
        endcase
      end
      T5: begin
        case (opc) inside
          [5'b00001:5'b01110]: begin
            if (opc == 5'b00010) begin ZLowout = 1'b1; MARin = 1'b1; end
            else begin ZLowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          end
          5'b00000: begin ZLowout = 1'b1; MARin = 1'b1; end
          5'b01111, 5'b10000: begin ZLowout = 1'b1; LOin = 1'b1; end
          5'b10011: begin Cout = 1'b1; ZLowin = 1'b1; OP = OPC_ADD; end
          default: ;
        endcase
      end
      T6: begin
        case (opc)
          5'b01111, 5'b10000: begin ZHighout = 1'b1; HIin = 1'b1; end
          5'b00000: begin Read = 1'b1; MDRin = 1'b1; end
          5'b00010: begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
          5'b10011: begin ZLowout = 1'b1; PCin = CON_FF; end
          default: ;
        endcase
      end
      T7: begin
        case (opc)
          5'b00000: begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          5'b00010: Write = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - directed-vector bench for control_sequencer
module tb_control_sequencer;

  logic        Clock, Clear, CON_FF, Stop;
  logic [31:0] IR;
  logic PCin, IRin, HIin, LOin, ZHighin, ZLowin, MARin, MDRin, OutPort, Yin;
  logic PCout, HIout, LOout, ZHighout, ZLowout, InPort, MDRout, Cout;
  logic Gra, Grb, Grc, Rin, Rout, BAout, Read, Write, IncPC, CON_In;
  logic [4:0] OP;
  logic Run;
  logic [27:0] strobes;

  int checks = 0;
  int errors = 0;

  control_sequencer dut (
    .Clock(Clock), .Clear(Clear), .IR(IR), .CON_FF(CON_FF), .Stop(Stop),
    .PCin(PCin), .IRin(IRin), .HIin(HIin), .LOin(LOin), .ZHighin(ZHighin), .ZLowin(ZLowin),
    .MARin(MARin), .MDRin(MDRin), .OutPort(OutPort), .Yin(Yin),
    .PCout(PCout), .HIout(HIout), .LOout(LOout), .ZHighout(ZHighout), .ZLowout(ZLowout),
    .InPort(InPort), .MDRout(MDRout), .Cout(Cout),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .Read(Read), .Write(Write), .IncPC(IncPC), .CON_In(CON_In),
    .OP(OP), .Run(Run)
  );

  assign strobes = {CON_In, IncPC, Write, Read, BAout, Rout, Rin, Grc, Grb, Gra,
                    Cout, MDRout, InPort, ZLowout, ZHighout, LOout, HIout, PCout,
                    Yin, OutPort, MDRin, MARin, ZLowin, ZHighin, LOin, HIin, IRin, PCin};

  localparam logic [27:0] PCIN = 28'd1 << 0,  IRIN = 28'd1 << 1,  HIIN = 28'd1 << 2,
    LOIN = 28'd1 << 3,  ZHIGHIN = 28'd1 << 4, ZLOWIN = 28'd1 << 5, MARIN = 28'd1 << 6,
    MDRIN = 28'd1 << 7, OUTPORT = 28'd1 << 8, YIN = 28'd1 << 9,   PCOUT = 28'd1 << 10,
    HIOUT = 28'd1 << 11, LOOUT = 28'd1 << 12, ZHIGHOUT = 28'd1 << 13, ZLOWOUT = 28'd1 << 14,
    INPORT = 28'd1 << 15, MDROUT = 28'd1 << 16, COUT = 28'd1 << 17, GRA = 28'd1 << 18,
    GRB = 28'd1 << 19, GRC = 28'd1 << 20, RIN = 28'd1 << 21, ROUT = 28'd1 << 22,
    BAOUT = 28'd1 << 23, READ = 28'd1 << 24, WRITE = 28'd1 << 25, INCPC = 28'd1 << 26,
    CONIN = 28'd1 << 27;
  localparam logic [27:0] F0 = PCOUT | MARIN | READ | MDRIN;
  localparam logic [27:0] NONE = 28'd0;

  initial begin
    Clock = 1'b1;
    forever #5 Clock = ~Clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [33:0] got, input logic [33:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got run/op/strobes=%h required=%h", tag, got, exp);
    end
  endtask

  task automatic step(input string tag, input logic [27:0] s, input logic [4:0] op, input logic run);
    @(negedge Clock);
    check(tag, {Run, OP, strobes}, {run, op, s});
  endtask

  task automatic now_check(input string tag, input logic [27:0] s, input logic [4:0] op, input logic run);
    check(tag, {Run, OP, strobes}, {run, op, s});
  endtask

  task automatic do_clear();
    @(negedge Clock);
    Clear = 1'b1;
    #1 now_check("reset", NONE, 5'd0, 1'b0);
    @(negedge Clock);
    Clear = 1'b0;
  endtask

  task automatic fetch(input string tag);
    step({tag, "_t0"}, F0, 5'd0, 1'b1);
    step({tag, "_t1"}, INCPC, 5'd0, 1'b1);
    step({tag, "_t2"}, MDROUT | IRIN, 5'd0, 1'b1);
  endtask

  task automatic br_run(input logic con);
    IR = 32'h9A800008;
    CON_FF = con;
    do_clear();
    fetch("br");
    step("br_t3", GRA | ROUT | CONIN, 5'd0, 1'b1);
    step("br_t4", PCOUT | YIN, 5'd0, 1'b1);
    step("br_t5", COUT | ZLOWIN, 5'b00011, 1'b1);
    step("br_t6", ZLOWOUT | (con ? PCIN : NONE), 5'd0, 1'b1);
    step("br_end", F0, 5'd0, 1'b1);
  endtask

  initial begin
    Clear = 1'b0; CON_FF = 1'b0; Stop = 1'b0;
    IR = 32'hC2000000;

    // mfhi: four cycles then a new fetch
    do_clear();
    fetch("mfhi");
    step("mfhi_t3", GRA | HIOUT | RIN, 5'd0, 1'b1);
    step("mfhi_end", F0, 5'd0, 1'b1);

    // add R1,R2,R3
    IR = 32'h18918000;
    do_clear();
    fetch("add");
    step("add_t3", GRB | ROUT | YIN, 5'd0, 1'b1);
    step("add_t4", GRC | ROUT | ZLOWIN, 5'b00011, 1'b1);
    step("add_t5", ZLOWOUT | GRA | RIN, 5'd0, 1'b1);
    step("add_end", F0, 5'd0, 1'b1);

    // ld R1,0x55(R2)
    IR = 32'h00900055;
    do_clear();
    fetch("ld");
    step("ld_t3", GRB | BAOUT | YIN, 5'd0, 1'b1);
    step("ld_t4", COUT | ZLOWIN, 5'b00011, 1'b1);
    step("ld_t5", ZLOWOUT | MARIN, 5'd0, 1'b1);
    step("ld_t6", READ | MDRIN, 5'd0, 1'b1);
    step("ld_t7", MDROUT | GRA | RIN, 5'd0, 1'b1);
    step("ld_end", F0, 5'd0, 1'b1);

    // ld again, Clear during T5
    do_clear();
    fetch("ldc");
    step("ldc_t3", GRB | BAOUT | YIN, 5'd0, 1'b1);
    step("ldc_t4", COUT | ZLOWIN, 5'b00011, 1'b1);
    step("ldc_t5", ZLOWOUT | MARIN, 5'd0, 1'b1);
    #2 Clear = 1'b1;
    #1 now_check("ldc_clear_now", NONE, 5'd0, 1'b0);
    step("ldc_clear_held", NONE, 5'd0, 1'b0);
    Clear = 1'b0;
    step("ldc_restart_t0", F0, 5'd0, 1'b1);
    step("ldc_restart_t1", INCPC, 5'd0, 1'b1);

    // st: T6 drives register onto MDR without Read, T7 writes
    IR = 32'h10900055;
    do_clear();
    fetch("st");
    step("st_t3", GRB | BAOUT | YIN, 5'd0, 1'b1);
    step("st_t4", COUT | ZLOWIN, 5'b00011, 1'b1);
    step("st_t5", ZLOWOUT | MARIN, 5'd0, 1'b1);
    step("st_t6", GRA | ROUT | MDRIN, 5'd0, 1'b1);
    step("st_t7", WRITE, 5'd0, 1'b1);
    step("st_end", F0, 5'd0, 1'b1);

    // brzr both ways
    br_run(1'b0);
    br_run(1'b1);
    CON_FF = 1'b0;

    // mul
    IR = 32'h78000000;
    do_clear();
    fetch("mul");
    step("mul_t3", GRA | ROUT | YIN, 5'd0, 1'b1);
    step("mul_t4", GRB | ROUT | ZHIGHIN | ZLOWIN, 5'b01111, 1'b1);
    step("mul_t5", ZLOWOUT | LOIN, 5'd0, 1'b1);
    step("mul_t6", ZHIGHOUT | HIIN, 5'd0, 1'b1);
    step("mul_end", F0, 5'd0, 1'b1);

    // neg
    IR = 32'h88000000;
    do_clear();
    fetch("neg");
    step("neg_t3", GRB | ROUT | ZLOWIN, 5'b10001, 1'b1);
    step("neg_t4", ZLOWOUT | GRA | RIN, 5'd0, 1'b1);
    step("neg_end", F0, 5'd0, 1'b1);

    // ori maps onto the or ALU code
    IR = 32'h70000000;
    do_clear();
    fetch("ori");
    step("ori_t3", GRB | ROUT | YIN, 5'd0, 1'b1);
    step("ori_t4", COUT | ZLOWIN, 5'b00110, 1'b1);
    step("ori_t5", ZLOWOUT | GRA | RIN, 5'd0, 1'b1);
    step("ori_end", F0, 5'd0, 1'b1);

    // halt
    IR = 32'hD8000000;
    do_clear();
    fetch("halt");
    step("halt_t3", NONE, 5'd0, 1'b1);
    for (int i = 0; i < 20; i++) step($sformatf("halt_hold%0d", i), NONE, 5'd0, 1'b0);
    do_clear();
    step("halt_restart", F0, 5'd0, 1'b1);

    // Stop raised during T1 of mfhi
    IR = 32'hC2000000;
    do_clear();
    step("stop_t0", F0, 5'd0, 1'b1);
    step("stop_t1", INCPC, 5'd0, 1'b1);
    Stop = 1'b1;
    step("stop_t2", MDROUT | IRIN, 5'd0, 1'b1);
    step("stop_t3", GRA | HIOUT | RIN, 5'd0, 1'b1);
    for (int i = 0; i < 4; i++) step($sformatf("stop_halt%0d", i), NONE, 5'd0, 1'b0);
    Stop = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Hardwired Moore control unit for the Mini-SRC datapath.
- Sequences fetch (T0–T2) and execute (T3–T7) steps from the instruction in the datapath IR.
- Drives every datapath control strobe, replacing the hand-driven T-state control used in unit benches.
- Sits beside the datapath. It takes IR[31:0] and CON_FF in, and sends control strobes out.

Parameters:
OPC_ADD  5'b00011  ALU code driven on OP for all address/offset calculations
OPC_HALT  5'b11011  opcode that enters HALT

Ports:
Clock  input  1  system clock, rising edge
Clear  input  1  asynchronous, active-high reset
IR  input  32  datapath IR contents; opcode IR[31:27], Ra IR[26:23], Rb IR[22:19], Rc IR[18:15]
CON_FF  input  1  branch condition flip-flop from datapath
Stop  input  1  level request: halt after the current instruction
PCin, IRin, HIin, LOin, ZHighin, ZLowin, MARin, MDRin, OutPort, Yin  output  1 each  register load enables
PCout, HIout, LOout, ZHighout, ZLowout, InPort, MDRout, Cout  output  1 each  bus drivers
Gra, Grb, Grc, Rin, Rout, BAout  output  1 each  register-file select and control
Read, Write, IncPC, CON_In  output  1 each  memory read/write, PC increment, CON_FF load
OP  output  5  ALU operation code
Run  output  1  1 while executing, 0 in reset or HALT

Behaviour:
- Reset:
  - Clear=1 forces state RST asynchronously.
  - All outputs are 0, OP=0, Run=0.
  - First rising edge with Clear=0 moves to T0.
  - Clear asserted mid-instruction drops all strobes in the same delta; no partial register write completes.
- Output timing:
  - Outputs are decoded combinationally from the state register and IR only.
  - Exactly one state per Clock.
  - Any strobe not listed for a state is 0. OP is 0 unless listed.
- Fetch:
  - T0: PCout MARin Read MDRin.
  - T1: IncPC.
  - T2: MDRout IRin.
- Execute (listed per state):
  - add/sub/and/or/shr/shra/shl/ror/rol (00011–01011): T3 Grb Rout Yin; T4 Grc Rout ZLowin OP=opcode; T5 ZLowout Gra Rin.
  - mul/div (01111, 10000): T3 Gra Rout Yin; T4 Grb Rout ZHighin ZLowin OP=opcode; T5 ZLowout LOin; T6 ZHighout HIin.
  - neg/not (10001, 10010): T3 Grb Rout ZLowin OP=opcode; T4 ZLowout Gra Rin.
  - addi/andi/ori (01100–01110): T3 Grb Rout Yin; T4 Cout ZLowin, OP=00011/00101/00110 respectively; T5 ZLowout Gra Rin.
  - ldi (00001): T3 Grb BAout Yin; T4 Cout ZLowin OP=OPC_ADD; T5 ZLowout Gra Rin.
  - ld (00000): same T3–T4 as ldi; T5 ZLowout MARin; T6 Read MDRin; T7 MDRout Gra Rin.
  - st (00010): same T3–T5 as ld; T6 Gra Rout MDRin (Read=0); T7 Write.
  - br (10011): T3 Gra Rout CON_In; T4 PCout Yin; T5 Cout ZLowin OP=OPC_ADD; T6 ZLowout, plus PCin only if CON_FF=1 during T6.
  - jr (10100): T3 Gra Rout PCin.
  - in (10110): T3 InPort Gra Rin.
  - out (10111): T3 Gra Rout OutPort.
  - mfhi (11000): T3 Gra HIout Rin.
  - mflo (11001): T3 Gra LOout Rin.
  - nop (11010), jal (10101) and undefined opcodes (11100–11111): T3 with no strobes.
  - halt (OPC_HALT): T3 → HALT.
- Completion and HALT:
  - After an instruction's last execute state, go to T0, or to HALT if Stop=1 at that edge.
  - HALT: all strobes 0, Run=0, held until Clear.
  - Stop is ignored during fetch and mid-instruction.
- Latency: mfhi/mflo/in/out/jr/nop take 4 cycles; ALU R-type and immediates take 6; mul/div, br and neg/not take 7/7/5; ld/st take 8.

Test Plan:
- Clear pulse at t=5 ns, then IR=32'hC2000000 (mfhi R4):
  - cycle 0: PCout MARin Read MDRin=1;
  - cycle 1: IncPC;
  - cycle 2: MDRout IRin;
  - cycle 3: Gra HIout Rin;
  - cycle 4: T0 again, Run=1 throughout.
- IR=32'h18918000 (add R1,R2,R3) → T4 shows Grc Rout ZLowin with OP=5'b00011; T5 ZLowout Gra Rin; instruction takes 6 cycles.
- IR=32'h00900055 (ld R1,0x55(R2)) → T3 BAout Grb Yin; T5 ZLowout MARin; T6 Read MDRin; T7 MDRout Gra Rin. Repeat the run with Clear asserted in T5: all outputs 0 immediately, and T0 on the first edge after release.
- IR=32'h9A800008 (brzr R5,8):
  - CON_FF=0 → T6 ZLowout=1 and PCin=0;
  - CON_FF=1 → T6 ZLowout=1 and PCin=1;
  - both cases return to T0 at cycle 7.
- IR=32'hD8000000 (halt) → after T3, Run=0 and every strobe stays 0 for 20 cycles; Clear restores T0 with Run=1.
- Stop=1 raised during T1 of mfhi → instruction completes through T3, then HALT (Run=0) with no further fetch.
